// File: rtl/window_gen_5x5_pkg.sv
// rtl/window_gen_5x5_pkg.sv - shared constants and window bit-offset helper
// Purpose: pixel width, window geometry and the packed-window layout function
//          used by window_gen_5x5 and its line buffers.
// Ports:   none (package).
package window_gen_5x5_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN_DIM  = 5;
    localparam int WIN_BITS = WIN_DIM * WIN_DIM * PIX_W;
    localparam int LB_COUNT = WIN_DIM - 1;

    // Bit offset of pixel (row r, col c) inside the packed window;
    // r = 0 is the oldest line, c = 0 the leftmost column.
    function automatic int win_bit_off(input int r, input int c);
        return (r * WIN_DIM + c) * PIX_W;
    endfunction

endpackage

// File: rtl/window_gen_5x5_line_buffer.sv
// rtl/window_gen_5x5_line_buffer.sv - one-line pixel delay (circular RAM)
// Purpose: delays a pixel stream by exactly DEPTH accepted pixels; dout is the
//          pixel written DEPTH advances ago, i.e. the same column one line up.
// Ports:   clk, rst (sync, active-high; clears pointer only), en (advance),
//          din (pixel in), dout (delayed pixel out).
module window_gen_5x5_line_buffer #(
    parameter int DEPTH = 64,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ptr;

    // Read-before-write at the same address gives a DEPTH-pixel delay.
    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

    // Contents are never reset: stale data is always overwritten before a
    // window can use it.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/window_gen_5x5.sv
// rtl/window_gen_5x5.sv - raster pixel stream to 5x5 sliding window generator
// Purpose: builds every fully-inside 5x5 window of a raster frame using four
//          line buffers and a 5x5 shift array; one pixel per cycle throughput.
// Ports:   clk, rst (sync, active-high)
//          pix_valid/pix_in/pix_sof/pix_ready : upstream pixel stream
//          win_valid/win_out/win_ready        : downstream window stream
//          frame_done                         : pulse after last frame pixel
//          win_row/win_col                    : window centre (WIN_COORD_EN only)
// Config:  define WIN_COORD_EN to add the win_row/win_col outputs.
module window_gen_5x5
    import window_gen_5x5_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_valid,
    input  logic [PIX_W-1:0]    pix_in,
    input  logic                pix_sof,
    output logic                pix_ready,
    output logic                win_valid,
    output logic [WIN_BITS-1:0] win_out,
    input  logic                win_ready,
`ifdef WIN_COORD_EN
    output logic [9:0]          win_row,
    output logic [9:0]          win_col,
`endif
    output logic                frame_done
);

    localparam logic [9:0] COL_LAST = 10'(IMG_WIDTH - 1);
    localparam logic [9:0] ROW_LAST = 10'(IMG_HEIGHT - 1);
    localparam logic [9:0] EDGE     = 10'(WIN_DIM - 1);

    logic [9:0] col;
    logic [9:0] row;
    logic [9:0] eff_col;
    logic [9:0] eff_row;
    logic       accept;
    logic       win_hit;
    logic       last_pix;

    // lb_chain[0] is the incoming pixel, lb_chain[k] the pixel k lines above.
    logic [PIX_W-1:0] lb_chain [LB_COUNT+1];

    assign pix_ready = !(win_valid && !win_ready);
    assign accept    = pix_valid && pix_ready;

    // A start-of-frame pixel is position (0,0) whatever the counters say.
    assign eff_col  = pix_sof ? '0 : col;
    assign eff_row  = pix_sof ? '0 : row;
    assign win_hit  = (eff_row >= EDGE) && (eff_col >= EDGE);
    assign last_pix = (eff_row == ROW_LAST) && (eff_col == COL_LAST);

    assign lb_chain[0] = pix_in;

    genvar g;
    generate
        for (g = 0; g < LB_COUNT; g++) begin : g_lb
            window_gen_5x5_line_buffer #(
                .DEPTH (IMG_WIDTH),
                .DW    (PIX_W)
            ) u_lb (
                .clk  (clk),
                .rst  (rst),
                .en   (accept),
                .din  (lb_chain[g]),
                .dout (lb_chain[g+1])
            );
        end
    endgenerate

    // win_out doubles as the 5x5 register array: it only shifts on an accepted
    // pixel, and no pixel is accepted while a window is stalled, so it stays
    // stable until the window is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_out    <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            col        <= '0;
            row        <= '0;
        end else begin
            frame_done <= accept && last_pix;
            if (accept) begin
                for (int r = 0; r < WIN_DIM; r++) begin
                    for (int c = 0; c < WIN_DIM; c++) begin
                        if (c < WIN_DIM - 1) begin
                            win_out[win_bit_off(r, c) +: PIX_W] <= win_out[win_bit_off(r, c + 1) +: PIX_W];
                        end else begin
                            win_out[win_bit_off(r, c) +: PIX_W] <= lb_chain[WIN_DIM - 1 - r];
                        end
                    end
                end
                // Also drops any pending window on a start-of-frame pixel
                // (win_hit is false at (0,0)).
                win_valid <= win_hit;
                if (eff_col == COL_LAST) begin
                    col <= '0;
                    row <= (eff_row == ROW_LAST) ? '0 : eff_row + 10'd1;
                end else begin
                    col <= eff_col + 10'd1;
                    row <= eff_row;
                end
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

`ifdef WIN_COORD_EN
    // Centre of the window produced by the accepted pixel at (eff_row, eff_col).
    always_ff @(posedge clk) begin
        if (rst) begin
            win_row <= '0;
            win_col <= '0;
        end else if (accept && win_hit) begin
            win_row <= eff_row - 10'd2;
            win_col <= eff_col - 10'd2;
        end
    end
`endif

endmodule

// File: tb/tb_window_gen_5x5.sv
// tb/tb_window_gen_5x5.sv - self-checking bench for window_gen_5x5 (8x8 frames)
module tb_window_gen_5x5;

    localparam int W = 8;
    localparam int H = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         pix_valid = 1'b0;
    logic [7:0]   pix_in = '0;
    logic         pix_sof = 1'b0;
    logic         pix_ready;
    logic         win_valid;
    logic [199:0] win_out;
    logic         win_ready = 1'b0;
    logic         frame_done;
`ifdef WIN_COORD_EN
    logic [9:0]   win_row;
    logic [9:0]   win_col;
`endif

    window_gen_5x5 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_in     (pix_in),
        .pix_sof    (pix_sof),
        .pix_ready  (pix_ready),
        .win_valid  (win_valid),
        .win_out    (win_out),
        .win_ready  (win_ready),
`ifdef WIN_COORD_EN
        .win_row    (win_row),
        .win_col    (win_col),
`endif
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the frame image as written so far and the raster position.
    logic [7:0]   mimg [H][W];
    int           mrow = 0;
    int           mcol = 0;
    bit           pend = 0;
    logic [199:0] exp_q [$];
    logic [199:0] obs_q [$];
    logic [19:0]  obs_cr_q [$];
    int           exp_fd, obs_fd, hs_err, cyc, first_v;
    logic [199:0] prev_out;
    bit           prev_valid, prev_xfer;
    bit           d_acc, d_rdy;

    function automatic logic [199:0] model_window(input int r0, input int c0);
        logic [199:0] w;
        w = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                w[(5 * r + c) * 8 +: 8] = mimg[r0 + r][c0 + c];
        return w;
    endfunction

    function automatic int first_mismatch();
        if (obs_q.size() != exp_q.size()) return obs_q.size();
        for (int k = 0; k < obs_q.size(); k++)
            if (obs_q[k] !== exp_q[k]) return k;
        return -1;
    endfunction

    task automatic clear_stats();
        exp_q.delete(); obs_q.delete(); obs_cr_q.delete();
        exp_fd = 0; obs_fd = 0; hs_err = 0; first_v = -1;
    endtask

    // One clock cycle: drive at the falling edge, sample 1 time unit later,
    // advance the model with the transfer that the next rising edge performs.
    task automatic step(input bit pv, input logic [7:0] pd, input bit sof,
                        input bit wr, output bit acc, output bit rdy);
        @(negedge clk);
        pix_valid = pv; pix_in = pd; pix_sof = sof; win_ready = wr;
        #1;
        cyc++;
        rdy = pix_ready;
        if (frame_done === 1'b1) obs_fd++;
        if (win_valid !== pend) hs_err++;
        if (pix_ready !== !(pend && !wr)) hs_err++;
        if (prev_valid && !prev_xfer && win_valid && win_out !== prev_out) hs_err++;
        if (win_valid === 1'b1 && first_v < 0) first_v = cyc;
        if (win_valid && wr) begin
            obs_q.push_back(win_out);
`ifdef WIN_COORD_EN
            obs_cr_q.push_back({win_row, win_col});
`endif
        end
        prev_valid = win_valid; prev_xfer = win_valid && wr; prev_out = win_out;
        acc = pv && !(pend && !wr);
        if (acc) begin
            if (sof) begin mrow = 0; mcol = 0; end
            mimg[mrow][mcol] = pd;
            pend = 0;
            if (mrow >= 4 && mcol >= 4) begin
                exp_q.push_back(model_window(mrow - 4, mcol - 4));
                pend = 1;
            end
            if (mrow == H - 1 && mcol == W - 1) exp_fd++;
            mcol++;
            if (mcol == W) begin
                mcol = 0; mrow++;
                if (mrow == H) mrow = 0;
            end
        end else if (wr) begin
            pend = 0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1; pix_valid = 0; pix_sof = 0; win_ready = 0;
        @(negedge clk);
        rst = 0;
        #1;
        if (pend) void'(exp_q.pop_back());
        pend = 0; mrow = 0; mcol = 0; prev_valid = 0; cyc++;
    endtask

    // n pixels with valid/ready held high; data is random or 8*row+col.
    task automatic feed(input int n, input bit sof_first, input bit rnd);
        for (int i = 0; i < n; i++)
            step(1, rnd ? 8'($urandom) : 8'(i), sof_first && i == 0, 1, d_acc, d_rdy);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 1, d_acc, d_rdy);
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (win_valid !== 1'b0) $display("FAIL reset_win_valid got %b exp 0", win_valid); else n_pass++;
        n_checks++; if (win_out !== '0) $display("FAIL reset_win_out got %h exp 0", win_out); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b exp 0", frame_done); else n_pass++;
        n_checks++; if (pix_ready !== 1'b1) $display("FAIL reset_pix_ready got %b exp 1", pix_ready); else n_pass++;
    endtask

    task automatic test_basic();
        logic [199:0] first;
        int mm;
        clear_stats();
        feed(64, 1, 0);
        drain();
        first = (obs_q.size() > 0) ? obs_q[0] : '1;
        mm = first_mismatch();
        n_checks++; if (obs_q.size() != 16) $display("FAIL basic_count got %0d exp 16", obs_q.size()); else n_pass++;
        n_checks++; if (mm != -1) $display("FAIL basic_content first bad window %0d of %0d", mm, obs_q.size()); else n_pass++;
        n_checks++; if (first[7:0] !== 8'd0) $display("FAIL basic_first_lo got %0d exp 0", first[7:0]); else n_pass++;
        n_checks++; if (first[199:192] !== 8'd36) $display("FAIL basic_first_hi got %0d exp 36", first[199:192]); else n_pass++;
        n_checks++; if (obs_fd != 1) $display("FAIL basic_frame_done got %0d exp 1", obs_fd); else n_pass++;
        n_checks++; if (hs_err != 0) $display("FAIL basic_handshake got %0d errors exp 0", hs_err); else n_pass++;
`ifdef WIN_COORD_EN
        n_checks++;
        if (obs_cr_q.size() != 16 || obs_cr_q[0] !== {10'd2, 10'd2} || obs_cr_q[15] !== {10'd5, 10'd5})
            $display("FAIL basic_coords first %h last %h exp 00802/01405", obs_cr_q[0], obs_cr_q[obs_cr_q.size() - 1]);
        else n_pass++;
`endif
    endtask

    task automatic test_stall();
        int idx, hold, stall_rdy;
        bit stalled, acc, rdy, wr;
        clear_stats();
        idx = 0; hold = 0; stalled = 0; stall_rdy = 0;
        for (int guard = 0; guard < 200 && idx < 64; guard++) begin
            wr = 1;
            if (pend && !stalled) begin stalled = 1; hold = 5; end
            if (hold > 0) begin wr = 0; hold--; end
            step(1, 8'(idx), idx == 0, wr, acc, rdy);
            if (!wr && rdy) stall_rdy++;
            if (acc) idx++;
        end
        drain();
        n_checks++; if (idx != 64) $display("FAIL stall_pixels got %0d exp 64", idx); else n_pass++;
        n_checks++; if (stall_rdy != 0) $display("FAIL stall_pix_ready got %0d ready cycles exp 0", stall_rdy); else n_pass++;
        n_checks++; if (obs_q.size() != 16) $display("FAIL stall_count got %0d exp 16", obs_q.size()); else n_pass++;
        n_checks++; if (first_mismatch() != -1) $display("FAIL stall_content first bad window %0d", first_mismatch()); else n_pass++;
        n_checks++; if (hs_err != 0) $display("FAIL stall_handshake got %0d errors exp 0", hs_err); else n_pass++;
    endtask

    task automatic test_random();
        int got;
        bit pv, acc, rdy;
        clear_stats();
        got = 0;
        for (int guard = 0; guard < 2000 && got < 64; guard++) begin
            pv = ($urandom_range(0, 3) != 0);
            step(pv, 8'($urandom), got == 0, $urandom_range(0, 9) < 7, acc, rdy);
            if (acc) got++;
        end
        drain();
        n_checks++; if (got != 64) $display("FAIL random_pixels got %0d exp 64", got); else n_pass++;
        n_checks++; if (obs_q.size() != 16) $display("FAIL random_count got %0d exp 16", obs_q.size()); else n_pass++;
        n_checks++; if (first_mismatch() != -1) $display("FAIL random_content first bad window %0d", first_mismatch()); else n_pass++;
        n_checks++; if (obs_fd != 1) $display("FAIL random_frame_done got %0d exp 1", obs_fd); else n_pass++;
        n_checks++; if (hs_err != 0) $display("FAIL random_handshake got %0d errors exp 0", hs_err); else n_pass++;
    endtask

    task automatic test_sof();
        int sof_cyc;
        clear_stats();
        feed(26, 1, 1);
        sof_cyc = cyc + 1;
        feed(64, 1, 0);
        drain();
        n_checks++; if (obs_q.size() != 16) $display("FAIL sof_count got %0d exp 16", obs_q.size()); else n_pass++;
        n_checks++; if (first_mismatch() != -1) $display("FAIL sof_content first bad window %0d", first_mismatch()); else n_pass++;
        n_checks++; if (first_v - sof_cyc != 37) $display("FAIL sof_first_window got %0d cycles exp 37", first_v - sof_cyc); else n_pass++;
        n_checks++; if (obs_fd != 1) $display("FAIL sof_frame_done got %0d exp 1", obs_fd); else n_pass++;
    endtask

    task automatic test_reset_mid();
        clear_stats();
        feed(46, 1, 1);
        step(0, 8'h00, 0, 0, d_acc, d_rdy);
        apply_reset();
        n_checks++; if (win_valid !== 1'b0) $display("FAIL midreset_win_valid got %b exp 0", win_valid); else n_pass++;
        clear_stats();
        feed(64, 0, 1);
        drain();
        n_checks++; if (obs_q.size() != 16) $display("FAIL midreset_count got %0d exp 16", obs_q.size()); else n_pass++;
        n_checks++; if (first_mismatch() != -1) $display("FAIL midreset_content first bad window %0d", first_mismatch()); else n_pass++;
        n_checks++; if (obs_fd != 1) $display("FAIL midreset_frame_done got %0d exp 1", obs_fd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_stats();
        feed(64, 1, 1);
        feed(64, 1, 1);
        drain();
        n_checks++; if (obs_q.size() != 32) $display("FAIL b2b_count got %0d exp 32", obs_q.size()); else n_pass++;
        n_checks++; if (first_mismatch() != -1) $display("FAIL b2b_content first bad window %0d", first_mismatch()); else n_pass++;
        n_checks++; if (obs_fd != 2) $display("FAIL b2b_frame_done got %0d exp 2", obs_fd); else n_pass++;
        n_checks++; if (hs_err != 0) $display("FAIL b2b_handshake got %0d errors exp 0", hs_err); else n_pass++;
    endtask

    initial begin
        cyc = 0;
        clear_stats();
        test_reset();
        test_basic();
        test_stall();
        test_random();
        test_sof();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
